// File: rtl/xgs_axil_regfile.sv
// -----------------------------------------------------------------------------
// xgs_axil_regfile
//   AXI4-Lite register file for the XGS sensor front end.
//
//   Register map (word decode on addr[AXIL_ADDR_WIDTH-1:2], addr[1:0] ignored):
//     0x000 ID          RO   0x5847_5331
//     0x004 SCRATCH     RW   byte-strobed
//     0x008 CTRL        bit0 irq_en (RW), bit1 soft_trig (write-only pulse),
//                       bits3:2 model_sel (RW), other bits read 0
//     0x00C IRQ_STATUS  bit0 event flag, write-1-to-clear
//     0x010 EVENT_CNT   RO   counts event_in cycles, wraps
//   Any other word returns SLVERR (reads give 0xDEAD_BEEF) and changes nothing.
//
// Ports:
//   aclk, aclk_reset_n        clock, asynchronous active-low reset
//   aclk_aw*/w*/b*/ar*/r*     AXI4-Lite slave (prot inputs ignored)
//   event_in                  single-cycle event pulse (sets flag, bumps count)
//   irq                       registered level interrupt = irq_en & flag
//   soft_trig                 one-cycle pulse after a CTRL write with bit1=1
//   model_sel                 sensor model selection (CTRL[3:2])
//
// Handshake semantics: a transfer happens on a rising edge where both valid
// and ready are high. Masters keep valid and payload stable until that edge;
// this slave keeps bvalid/bresp and rvalid/rdata/rresp stable until the
// matching ready is sampled high. Ready outputs never depend combinationally
// on valid inputs.
// -----------------------------------------------------------------------------
module xgs_axil_regfile #(
  parameter int AXIL_ADDR_WIDTH = 11,
  parameter int AXIL_DATA_WIDTH = 32
) (
  input  logic                         aclk,
  input  logic                         aclk_reset_n,
  // AW channel
  input  logic [AXIL_ADDR_WIDTH-1:0]   aclk_awaddr,
  input  logic [2:0]                   aclk_awprot,
  input  logic                         aclk_awvalid,
  output logic                         aclk_awready,
  // W channel
  input  logic [AXIL_DATA_WIDTH-1:0]   aclk_wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0] aclk_wstrb,
  input  logic                         aclk_wvalid,
  output logic                         aclk_wready,
  // B channel
  output logic [1:0]                   aclk_bresp,
  output logic                         aclk_bvalid,
  input  logic                         aclk_bready,
  // AR channel
  input  logic [AXIL_ADDR_WIDTH-1:0]   aclk_araddr,
  input  logic [2:0]                   aclk_arprot,
  input  logic                         aclk_arvalid,
  output logic                         aclk_arready,
  // R channel
  output logic [AXIL_DATA_WIDTH-1:0]   aclk_rdata,
  output logic [1:0]                   aclk_rresp,
  output logic                         aclk_rvalid,
  input  logic                         aclk_rready,
  // Sideband
  input  logic                         event_in,
  output logic                         irq,
  output logic                         soft_trig,
  output logic [1:0]                   model_sel
);

  localparam int IDX_W = AXIL_ADDR_WIDTH - 2;
  localparam int DW    = AXIL_DATA_WIDTH;
  localparam int SW    = AXIL_DATA_WIDTH / 8;

  localparam logic [IDX_W-1:0] IDX_ID      = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_SCRATCH = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_CTRL    = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_STATUS  = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_CNT     = IDX_W'(4);

  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;
  localparam logic [DW-1:0] ID_VALUE    = DW'(32'h5847_5331);
  localparam logic [DW-1:0] BAD_VALUE   = DW'(32'hDEAD_BEEF);

  // rst_done_q holds all readies low until the first edge after reset release
  logic             rst_done_q,  rst_done_d;
  logic             aw_full_q,   aw_full_d;
  logic [IDX_W-1:0] aw_idx_q,    aw_idx_d;
  logic             w_full_q,    w_full_d;
  logic [DW-1:0]    w_data_q,    w_data_d;
  logic [SW-1:0]    w_strb_q,    w_strb_d;
  logic             bvalid_q,    bvalid_d;
  logic [1:0]       bresp_q,     bresp_d;
  logic             rvalid_q,    rvalid_d;
  logic [1:0]       rresp_q,     rresp_d;
  logic [DW-1:0]    rdata_q,     rdata_d;
  logic [DW-1:0]    scratch_q,   scratch_d;
  logic             irq_en_q,    irq_en_d;
  logic [1:0]       model_sel_q, model_sel_d;
  logic             status_q,    status_d;
  logic [DW-1:0]    event_cnt_q, event_cnt_d;
  logic             irq_q,       irq_d;
  logic             soft_trig_q, soft_trig_d;

  logic             aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0] rd_idx;
  logic [DW-1:0]    rd_data;
  logic [1:0]       rd_resp;

  logic unused_bits;
  assign unused_bits = ^{aclk_awprot, aclk_arprot, aclk_awaddr[1:0], aclk_araddr[1:0]};

  assign aclk_awready = rst_done_q & ~aw_full_q & ~bvalid_q;
  assign aclk_wready  = rst_done_q & ~w_full_q  & ~bvalid_q;
  assign aclk_arready = rst_done_q & ~rvalid_q;
  assign aclk_bvalid  = bvalid_q;
  assign aclk_bresp   = bresp_q;
  assign aclk_rvalid  = rvalid_q;
  assign aclk_rresp   = rresp_q;
  assign aclk_rdata   = rdata_q;
  assign irq          = irq_q;
  assign soft_trig    = soft_trig_q;
  assign model_sel    = model_sel_q;

  assign aw_hs  = aclk_awvalid & aclk_awready;
  assign w_hs   = aclk_wvalid  & aclk_wready;
  assign ar_hs  = aclk_arvalid & aclk_arready;
  // Holders only fill while bvalid is low, so a commit can never overlap an
  // outstanding response.
  assign commit = aw_full_q & w_full_q & ~bvalid_q;

  // Read mux works from current register values, so a read landing on the
  // same edge as a write commit returns the pre-write contents.
  assign rd_idx = aclk_araddr[AXIL_ADDR_WIDTH-1:2];
  always_comb begin
    rd_data = BAD_VALUE;
    rd_resp = RESP_SLVERR;
    case (rd_idx)
      IDX_ID:      begin rd_data = ID_VALUE;    rd_resp = RESP_OKAY; end
      IDX_SCRATCH: begin rd_data = scratch_q;   rd_resp = RESP_OKAY; end
      IDX_CTRL:    begin
        rd_data      = '0;
        rd_data[0]   = irq_en_q;
        rd_data[3:2] = model_sel_q;
        rd_resp      = RESP_OKAY;
      end
      IDX_STATUS:  begin
        rd_data    = '0;
        rd_data[0] = status_q;
        rd_resp    = RESP_OKAY;
      end
      IDX_CNT:     begin rd_data = event_cnt_q; rd_resp = RESP_OKAY; end
      default:     ;
    endcase
  end

  always_comb begin
    rst_done_d  = 1'b1;
    aw_full_d   = aw_full_q;
    aw_idx_d    = aw_idx_q;
    w_full_d    = w_full_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    scratch_d   = scratch_q;
    irq_en_d    = irq_en_q;
    model_sel_d = model_sel_q;
    status_d    = status_q;
    event_cnt_d = event_cnt_q;
    soft_trig_d = 1'b0;
    irq_d       = irq_en_q & status_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = aclk_awaddr[AXIL_ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = aclk_wdata;
      w_strb_d = aclk_wstrb;
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (aw_idx_q <= IDX_CNT) ? RESP_OKAY : RESP_SLVERR;
      case (aw_idx_q)
        IDX_SCRATCH: begin
          for (int b = 0; b < SW; b++) begin
            if (w_strb_q[b]) scratch_d[8*b +: 8] = w_data_q[8*b +: 8];
          end
        end
        IDX_CTRL: begin
          if (w_strb_q[0]) begin
            irq_en_d    = w_data_q[0];
            soft_trig_d = w_data_q[1];
            model_sel_d = w_data_q[3:2];
          end
        end
        IDX_STATUS: begin
          if (w_strb_q[0] && w_data_q[0]) status_d = 1'b0;
        end
        default: ;
      endcase
    end else if (bvalid_q && aclk_bready) begin
      bvalid_d = 1'b0;
    end

    // Placed after the W1C so a simultaneous event wins and the flag stays set.
    if (event_in) begin
      status_d    = 1'b1;
      event_cnt_d = event_cnt_q + DW'(1);
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data;
      rresp_d  = rd_resp;
    end else if (rvalid_q && aclk_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aclk_reset_n) begin
    if (!aclk_reset_n) begin
      rst_done_q  <= 1'b0;
      aw_full_q   <= 1'b0;
      aw_idx_q    <= '0;
      w_full_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      scratch_q   <= '0;
      irq_en_q    <= 1'b0;
      model_sel_q <= 2'b00;
      status_q    <= 1'b0;
      event_cnt_q <= '0;
      irq_q       <= 1'b0;
      soft_trig_q <= 1'b0;
    end else begin
      rst_done_q  <= rst_done_d;
      aw_full_q   <= aw_full_d;
      aw_idx_q    <= aw_idx_d;
      w_full_q    <= w_full_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      scratch_q   <= scratch_d;
      irq_en_q    <= irq_en_d;
      model_sel_q <= model_sel_d;
      status_q    <= status_d;
      event_cnt_q <= event_cnt_d;
      irq_q       <= irq_d;
      soft_trig_q <= soft_trig_d;
    end
  end

endmodule

// File: tb/tb_xgs_axil_regfile.sv
// -----------------------------------------------------------------------------
// tb_xgs_axil_regfile
//   Directed scenarios followed by randomized AXI4-Lite traffic and event
//   pulses, compared against a register-level reference model.
// -----------------------------------------------------------------------------
module tb_xgs_axil_regfile;

  // ---------------------------------------------------------------- clock/reset
  logic        aclk;
  logic        aclk_reset_n;
  logic [10:0] aclk_awaddr;
  logic [2:0]  aclk_awprot;
  logic        aclk_awvalid;
  logic        aclk_awready;
  logic [31:0] aclk_wdata;
  logic [3:0]  aclk_wstrb;
  logic        aclk_wvalid;
  logic        aclk_wready;
  logic [1:0]  aclk_bresp;
  logic        aclk_bvalid;
  logic        aclk_bready;
  logic [10:0] aclk_araddr;
  logic [2:0]  aclk_arprot;
  logic        aclk_arvalid;
  logic        aclk_arready;
  logic [31:0] aclk_rdata;
  logic [1:0]  aclk_rresp;
  logic        aclk_rvalid;
  logic        aclk_rready;
  logic        event_in;
  logic        irq;
  logic        soft_trig;
  logic [1:0]  model_sel;

  xgs_axil_regfile #(.AXIL_ADDR_WIDTH(11), .AXIL_DATA_WIDTH(32)) dut (
    .aclk(aclk), .aclk_reset_n(aclk_reset_n),
    .aclk_awaddr(aclk_awaddr), .aclk_awprot(aclk_awprot),
    .aclk_awvalid(aclk_awvalid), .aclk_awready(aclk_awready),
    .aclk_wdata(aclk_wdata), .aclk_wstrb(aclk_wstrb),
    .aclk_wvalid(aclk_wvalid), .aclk_wready(aclk_wready),
    .aclk_bresp(aclk_bresp), .aclk_bvalid(aclk_bvalid), .aclk_bready(aclk_bready),
    .aclk_araddr(aclk_araddr), .aclk_arprot(aclk_arprot),
    .aclk_arvalid(aclk_arvalid), .aclk_arready(aclk_arready),
    .aclk_rdata(aclk_rdata), .aclk_rresp(aclk_rresp),
    .aclk_rvalid(aclk_rvalid), .aclk_rready(aclk_rready),
    .event_in(event_in), .irq(irq), .soft_trig(soft_trig), .model_sel(model_sel)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------ scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [33:0] exp_q[$];   // {rresp, rdata}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // --------------------------------------------------------------- reference model
  logic [31:0] m_scratch;
  logic        m_irq_en;
  logic [1:0]  m_model;
  logic        m_status;
  logic [31:0] m_cnt;

  function automatic void model_reset();
    m_scratch = '0; m_irq_en = 1'b0; m_model = 2'b00; m_status = 1'b0; m_cnt = '0;
  endfunction

  function automatic void model_write(input logic [10:0] addr, input logic [31:0] d,
                                      input logic [3:0] s, output logic [1:0] resp,
                                      output int trig);
    int idx;
    idx  = int'(addr >> 2);
    trig = 0;
    resp = 2'b00;
    if (idx == 1) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
    end else if (idx == 2) begin
      if (s[0]) begin m_irq_en = d[0]; m_model = d[3:2]; trig = int'(d[1]); end
    end else if (idx == 3) begin
      if (s[0] && d[0]) m_status = 1'b0;
    end else if (idx > 4) begin
      resp = 2'b10;
    end
  endfunction

  function automatic logic [33:0] model_read(input logic [10:0] addr);
    int idx;
    idx = int'(addr >> 2);
    case (idx)
      0: return {2'b00, 32'h5847_5331};
      1: return {2'b00, m_scratch};
      2: return {2'b00, 28'd0, m_model, 1'b0, m_irq_en};
      3: return {2'b00, 31'd0, m_status};
      4: return {2'b00, m_cnt};
      default: return {2'b10, 32'hDEAD_BEEF};
    endcase
  endfunction

  function automatic logic [10:0] pick_addr();
    logic [10:0] a;
    int k;
    k = $urandom_range(0, 6);
    if (k < 5) a = 11'(k * 4);
    else a = 11'($urandom_range(5, 511) * 4);
    a[1:0] = 2'($urandom_range(0, 3));
    return a;
  endfunction

  // -------------------------------------------------------------------- drivers
  // W is presented w_lead cycles before AW; bready stays high.
  task automatic axi_write(input logic [10:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead,
                           output logic [1:0] resp, output int trig_cycles);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    trig_cycles = 0;
    aclk_wdata = data; aclk_wstrb = strb; aclk_wvalid = 1'b1;
    aclk_awaddr = addr; aclk_awvalid = 1'b0;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 100) begin
      if (cyc == w_lead) aclk_awvalid = 1'b1;
      aw_hs = aclk_awvalid && aclk_awready;
      w_hs  = aclk_wvalid && aclk_wready;
      @(posedge aclk); #1;
      if (soft_trig) trig_cycles++;
      if (aw_hs) begin aclk_awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin aclk_wvalid  = 1'b0; w_done  = 1; end
      cyc++;
    end
    aclk_awvalid = 1'b0; aclk_wvalid = 1'b0;
    check("aw_w_accepted", {aw_done, w_done}, 2'b11);
    cyc = 0;
    while (!aclk_bvalid && cyc < 20) begin
      @(posedge aclk); #1;
      if (soft_trig) trig_cycles++;
      cyc++;
    end
    check("bvalid_seen", aclk_bvalid, 1'b1);
    resp = aclk_bresp;
    @(posedge aclk); #1;
    if (soft_trig) trig_cycles++;
  endtask

  task automatic axi_read(input logic [10:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int cyc;
    aclk_araddr = addr; aclk_arvalid = 1'b1; cyc = 0;
    while (!aclk_arready && cyc < 20) begin @(posedge aclk); #1; cyc++; end
    @(posedge aclk); #1;
    aclk_arvalid = 1'b0;
    check("rvalid_1cyc", aclk_rvalid, 1'b1);
    data = aclk_rdata;
    resp = aclk_rresp;
    @(posedge aclk); #1;
  endtask

  // AW and W together; optional event pulse and AR land on the commit edge.
  task automatic write_sync(input logic [10:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input bit ev, input bit do_rd,
                            input logic [10:0] rd_addr, output logic [1:0] bresp,
                            output logic [31:0] rdata);
    check("sync_ready", {aclk_awready, aclk_wready}, 2'b11);
    aclk_awaddr = addr; aclk_awvalid = 1'b1;
    aclk_wdata = data; aclk_wstrb = strb; aclk_wvalid = 1'b1;
    @(posedge aclk); #1;
    aclk_awvalid = 1'b0; aclk_wvalid = 1'b0;
    if (ev) event_in = 1'b1;
    if (do_rd) begin aclk_araddr = rd_addr; aclk_arvalid = 1'b1; end
    @(posedge aclk); #1;
    event_in = 1'b0; aclk_arvalid = 1'b0;
    check("sync_bvalid", aclk_bvalid, 1'b1);
    bresp = aclk_bresp;
    rdata = aclk_rdata;
    @(posedge aclk); #1;
  endtask

  task automatic event_pulse();
    event_in = 1'b1;
    @(posedge aclk); #1;
    event_in = 1'b0;
    m_status = 1'b1;
    m_cnt    = m_cnt + 1;
    @(posedge aclk); #1;
  endtask

  task automatic read_expect(input string tag, input logic [10:0] addr);
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [33:0] e;
    exp_q.push_back(model_read(addr));
    axi_read(addr, rd, rr);
    e = exp_q.pop_front();
    check(tag, {rr, rd}, e);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 5; i++) read_expect(tag, 11'(i * 4));
  endtask

  // ----------------------------------------------------------------- main flow
  logic [31:0] rd;
  logic [1:0]  rr, br, ebr;
  int          trig, etrig;
  bit          hold_ok, quiet_ok;

  initial begin
    aclk_reset_n = 1'b0;
    aclk_awaddr = '0; aclk_awprot = 3'd0; aclk_awvalid = 1'b0;
    aclk_wdata = '0; aclk_wstrb = '0; aclk_wvalid = 1'b0;
    aclk_bready = 1'b1;
    aclk_araddr = '0; aclk_arprot = 3'd0; aclk_arvalid = 1'b0;
    aclk_rready = 1'b1;
    event_in = 1'b0;
    model_reset();

    repeat (3) @(posedge aclk);
    #1;
    check("rst_readies", {aclk_awready, aclk_wready, aclk_arready}, 3'b000);
    check("rst_valids", {aclk_bvalid, aclk_rvalid}, 2'b00);
    check("rst_resps", {aclk_bresp, aclk_rresp}, 4'b0000);
    check("rst_rdata", aclk_rdata, 32'h0);
    check("rst_side", {irq, soft_trig, model_sel}, 4'b0000);
    aclk_reset_n = 1'b1;
    @(posedge aclk); #1;
    check("post_rst_readies", {aclk_awready, aclk_wready, aclk_arready}, 3'b111);

    // ID read
    axi_read(11'h000, rd, rr);
    check("id_rdata", rd, 32'h5847_5331);
    check("id_rresp", rr, 2'b00);

    // SCRATCH byte strobes with W leading AW by 3 cycles
    model_write(11'h004, 32'hFFFF_FFFF, 4'hF, ebr, etrig);
    axi_write(11'h004, 32'hFFFF_FFFF, 4'hF, 0, br, trig);
    model_write(11'h004, 32'hA5A5_1234, 4'b0011, ebr, etrig);
    axi_write(11'h004, 32'hA5A5_1234, 4'b0011, 3, br, trig);
    check("scratch_bresp", br, 2'b00);
    check("single_b", aclk_bvalid, 1'b0);
    axi_read(11'h004, rd, rr);
    check("scratch_merge", rd, 32'hFFFF_1234);

    // CTRL write with soft trigger
    model_write(11'h008, 32'h0000_000B, 4'hF, ebr, etrig);
    axi_write(11'h008, 32'h0000_000B, 4'hF, 0, br, trig);
    check("soft_trig_cycles", trig, 1);
    check("model_sel", model_sel, 2'b10);
    quiet_ok = 1;
    repeat (3) begin if (soft_trig) quiet_ok = 0; @(posedge aclk); #1; end
    check("soft_trig_quiet", quiet_ok, 1'b1);
    axi_read(11'h008, rd, rr);
    check("ctrl_readback", rd, 32'h0000_0009);

    // Events, interrupt, W1C collision with event
    check("irq_idle", irq, 1'b0);
    repeat (3) event_pulse();
    check("irq_after_events", irq, 1'b1);
    axi_read(11'h010, rd, rr);
    check("event_cnt_3", rd, 32'd3);
    model_write(11'h00C, 32'h1, 4'h1, ebr, etrig);
    m_status = 1'b1; m_cnt = m_cnt + 1;
    write_sync(11'h00C, 32'h1, 4'h1, 1'b1, 1'b0, 11'h0, br, rd);
    axi_read(11'h00C, rd, rr);
    check("w1c_vs_event", rd, 32'h1);
    axi_read(11'h010, rd, rr);
    check("event_cnt_4", rd, 32'd4);
    model_write(11'h00C, 32'h1, 4'h1, ebr, etrig);
    axi_write(11'h00C, 32'h1, 4'h1, 1, br, trig);
    check("w1c_clears_irq", irq, 1'b0);

    // Read on the commit edge returns the old value
    model_write(11'h004, 32'h0BAD_F00D, 4'hF, ebr, etrig);
    write_sync(11'h004, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b1, 11'h004, br, rd);
    check("read_pre_write", rd, 32'hFFFF_1234);
    axi_read(11'h004, rd, rr);
    check("read_post_write", rd, 32'h0BAD_F00D);

    // Unmapped address
    axi_write(11'h7FC, 32'hFFFF_FFFF, 4'hF, 0, br, trig);
    check("unmapped_bresp", br, 2'b10);
    axi_read(11'h7FC, rd, rr);
    check("unmapped_rdata", rd, 32'hDEAD_BEEF);
    check("unmapped_rresp", rr, 2'b10);
    read_all("no_change");

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      int op;
      logic [10:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      op = $urandom_range(0, 9);
      a  = pick_addr();
      aclk_awprot = 3'($urandom_range(0, 7));
      aclk_arprot = 3'($urandom_range(0, 7));
      if (op < 4) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        model_write(a, d, s, ebr, etrig);
        axi_write(a, d, s, $urandom_range(0, 3), br, trig);
        check("rnd_bresp", br, ebr);
        check("rnd_soft_trig", trig, etrig);
      end else if (op < 8) begin
        read_expect("rnd_read", a);
      end else begin
        repeat ($urandom_range(1, 3)) event_pulse();
      end
      check("rnd_irq", irq, m_irq_en & m_status);
      check("rnd_model_sel", model_sel, m_model);
    end
    read_all("rnd_final");

    // Back-pressured B, then reset during the hold
    aclk_bready = 1'b0;
    model_write(11'h004, 32'h1357_9BDF, 4'hF, ebr, etrig);
    aclk_awaddr = 11'h004; aclk_awvalid = 1'b1;
    aclk_wdata = 32'h1357_9BDF; aclk_wstrb = 4'hF; aclk_wvalid = 1'b1;
    @(posedge aclk); #1;
    aclk_awvalid = 1'b0; aclk_wvalid = 1'b0;
    @(posedge aclk); #1;
    hold_ok = 1;
    repeat (10) begin
      if (!aclk_bvalid || aclk_bresp != 2'b00 || aclk_awready || aclk_wready) hold_ok = 0;
      @(posedge aclk); #1;
    end
    check("b_hold_10", hold_ok, 1'b1);
    check("b_still_valid", aclk_bvalid, 1'b1);
    aclk_reset_n = 1'b0;
    #1;
    check("rst_mid_bvalid", aclk_bvalid, 1'b0);
    check("rst_mid_readies", {aclk_awready, aclk_wready, aclk_arready}, 3'b000);
    check("rst_mid_side", {irq, soft_trig, model_sel}, 4'b0000);
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    aclk_bready = 1'b1;
    aclk_reset_n = 1'b1;
    @(posedge aclk); #1;
    check("rerelease_readies", {aclk_awready, aclk_wready, aclk_arready}, 3'b111);
    quiet_ok = 1;
    repeat (5) begin if (aclk_bvalid || aclk_rvalid) quiet_ok = 0; @(posedge aclk); #1; end
    check("no_stale_response", quiet_ok, 1'b1);
    read_all("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xgs_axil_regfile.md
XGS_AXIL_REGFILE -- requirements
Module: xgs_axil_regfile

Interface
REQ-001 SHALL have parameter AXIL_ADDR_WIDTH, default 11, byte-address width of the AXI4-Lite slave port.
REQ-002 SHALL have parameter AXIL_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have port aclk, input, 1, the single clock for all logic.
REQ-004 SHALL have port aclk_reset_n, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have AW channel ports: aclk_awaddr in AXIL_ADDR_WIDTH, aclk_awprot in 3 (ignored), aclk_awvalid in 1, aclk_awready out 1.
REQ-006 SHALL have W channel ports: aclk_wdata in 32, aclk_wstrb in 4, aclk_wvalid in 1, aclk_wready out 1.
REQ-007 SHALL have B channel ports: aclk_bresp out 2, aclk_bvalid out 1, aclk_bready in 1.
REQ-008 SHALL have AR channel ports: aclk_araddr in AXIL_ADDR_WIDTH, aclk_arprot in 3 (ignored), aclk_arvalid in 1, aclk_arready out 1.
REQ-009 SHALL have R channel ports: aclk_rdata out 32, aclk_rresp out 2, aclk_rvalid out 1, aclk_rready in 1.
REQ-010 SHALL have port event_in, input, 1, single-cycle event pulse (e.g. DMA frame done).
REQ-011 SHALL have port irq, output, 1, level interrupt.
REQ-012 SHALL have port soft_trig, output, 1, one-cycle software trigger pulse.
REQ-013 SHALL have port model_sel, output, 2, sensor model selection.

Function
REQ-014 SHALL decode addr[AXIL_ADDR_WIDTH-1:2], ignoring addr[1:0], using this map:
- 0x000 ID: RO, 0x5847_5331.
- 0x004 SCRATCH: RW, reset 0.
- 0x008 CTRL: bit0 irq_en RW; bit1 soft_trig W-only, reads 0; bits3:2 model_sel RW; other bits read 0.
- 0x00C IRQ_STATUS: bit0 event flag, W1C.
- 0x010 EVENT_CNT: RO, 32-bit, wraps 0xFFFF_FFFF->0.
REQ-015 SHALL accept AW and W independently, each into a one-deep holding register; aclk_awready=1 iff AW holder empty and bvalid=0; aclk_wready likewise for W.
REQ-016 SHALL commit the write on the first edge where both holders are full and bvalid=0, set bvalid on that same edge, and empty both holders.
REQ-017 SHALL apply wstrb per byte to SCRATCH and CTRL; for IRQ_STATUS and soft_trig, use byte 0 only, gated by wstrb[0].
REQ-018 SHALL hold bvalid and bresp stable until bready; bvalid clears on the edge where bvalid&bready.
REQ-019 SHALL return bresp=OKAY(00) for mapped addresses; writes to ID/EVENT_CNT are ignored with OKAY; unmapped addresses return SLVERR(10) with no state change.
REQ-020 SHALL drive aclk_arready=~rvalid; on AR handshake it registers rdata, rresp and rvalid=1 on the next edge (1-cycle latency).
REQ-021 SHALL hold rdata/rresp until rready; unmapped reads return rdata=0xDEAD_BEEF, rresp=SLVERR.
REQ-022 SHALL pulse soft_trig high for exactly one cycle, on the cycle after a commit writing CTRL bit1=1.
REQ-023 SHALL set IRQ_STATUS bit0 and increment EVENT_CNT on every cycle event_in=1.
REQ-024 SHALL give set priority when event_in and a W1C of IRQ_STATUS bit0 land on the same edge: the bit stays 1.
REQ-025 SHALL drive irq as a registered output, irq = irq_en & IRQ_STATUS[0], one cycle after either input changes.
REQ-026 SHALL keep the read and write paths fully concurrent, and a read in the same cycle as a write commit to the same register SHALL return the pre-write value.

Reset
REQ-027 SHALL force, while aclk_reset_n=0: all ready/valid outputs 0, bresp/rresp 00, rdata 0, irq 0, soft_trig 0, model_sel 00, SCRATCH/CTRL/IRQ_STATUS/EVENT_CNT 0, holders empty.
REQ-028 SHALL discard in-flight transactions on reset assertion mid-transaction, with no response issued after release.
REQ-029 SHALL assert awready, wready and arready on the first edge after reset release.

Verification
REQ-030 Bench SHALL cover: read 0x000 -> rdata 0x5847_5331, rresp 00, rvalid 1 cycle after AR handshake.
REQ-031 Bench SHALL cover: W presented 3 cycles before AW, 0xA5A5_1234 to 0x004 with wstrb 0011 (SCRATCH previously 0xFFFF_FFFF) -> one B OKAY; readback 0xFFFF_1234.
REQ-032 Bench SHALL cover: CTRL write 0x0000_000B -> soft_trig high exactly 1 cycle; model_sel=2'b10; CTRL readback 0x0000_0009.
REQ-033 Bench SHALL cover: irq_en=1, then 3 event_in pulses -> irq=1, EVENT_CNT=3; a W1C issued on the same edge as a 4th pulse leaves bit0=1 and EVENT_CNT=4.
REQ-034 Bench SHALL cover: write and read of 0x7FC -> bresp 10, rresp 10, rdata 0xDEAD_BEEF, no register changes.
REQ-035 Bench SHALL cover: bready held 0 for 10 cycles -> bvalid held, awready=0 throughout; reset asserted mid-hold -> bvalid=0 immediately.
